// File: rtl/range_finder_stats.sv
// Streaming min/max/range/count tracker between go and finish strobes.
// Results are registered and published with a one-cycle done pulse; protocol misuse sets a sticky error.
module range_finder_stats #(
   parameter int unsigned WIDTH     = 8,
   parameter int unsigned CNT_WIDTH = 16,
   parameter int unsigned SIGNED    = 0
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic [WIDTH-1:0]     data_in,
   input  logic                 go,
   input  logic                 finish,
   output logic [WIDTH-1:0]     range,
   output logic [WIDTH-1:0]     min_out,
   output logic [WIDTH-1:0]     max_out,
   output logic [CNT_WIDTH-1:0] count,
   output logic                 valid,
   output logic                 done,
   output logic                 busy,
   output logic                 debug_error
);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      ERROR
   } state_t;

   state_t               state, state_nxt;
   logic [WIDTH-1:0]     min_q, max_q;
   logic [WIDTH-1:0]     smp_min, smp_max;
   logic [CNT_WIDTH-1:0] cnt_q, cnt_inc;
   logic                 start;

   function automatic logic lt(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      if (SIGNED != 0) return $signed(a) < $signed(b);
      else             return a < b;
   endfunction

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (finish)  state_nxt = ERROR;
            else if (go) state_nxt = RUN;
         end
         RUN: begin
            if (finish) state_nxt = IDLE;
         end
         ERROR: begin
            if (go && !finish) state_nxt = RUN;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      start   = (state != RUN) && (state_nxt == RUN);
      smp_min = lt(data_in, min_q) ? data_in : min_q;
      smp_max = lt(max_q, data_in) ? data_in : max_q;
      cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CNT_WIDTH'(1);
   end

   always_ff @(posedge clock) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   assign busy = (state == RUN);

   always_ff @(posedge clock) begin
      if (reset) begin
         min_q       <= '0;
         max_q       <= '0;
         cnt_q       <= '0;
         range       <= '0;
         min_out     <= '0;
         max_out     <= '0;
         count       <= '0;
         valid       <= 1'b0;
         done        <= 1'b0;
         debug_error <= 1'b0;
      end else begin
         done <= 1'b0;
         if (start) begin
            min_q       <= data_in;
            max_q       <= data_in;
            cnt_q       <= CNT_WIDTH'(1);
            valid       <= 1'b0;
            debug_error <= 1'b0;
         end else if (state == IDLE && finish) begin
            debug_error <= 1'b1;
            valid       <= 1'b0;
         end else if (state == RUN) begin
            min_q <= smp_min;
            max_q <= smp_max;
            cnt_q <= cnt_inc;
            // Published values fold in the finish-cycle sample directly.
            if (finish) begin
               min_out <= smp_min;
               max_out <= smp_max;
               range   <= smp_max - smp_min;
               count   <= cnt_inc;
               valid   <= 1'b1;
               done    <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_range_finder_stats.sv
// Self-checking bench: one unsigned/4-bit-count instance and one signed/16-bit-count instance
// share stimulus and are compared each cycle against a sample-list reference model.
module tb_range_finder_stats;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] data_in = '0;
   logic       go = 1'b0;
   logic       finish = 1'b0;

   logic [7:0]  a_range, a_min, a_max;
   logic [3:0]  a_count;
   logic        a_valid, a_done, a_busy, a_err;
   logic [7:0]  b_range, b_min, b_max;
   logic [15:0] b_count;
   logic        b_valid, b_done, b_busy, b_err;

   int total = 0;
   int bad   = 0;

   always #5 clock = ~clock;

   range_finder_stats #(.WIDTH(8), .CNT_WIDTH(4), .SIGNED(0)) dut_u (
      .clock(clock), .reset(reset), .data_in(data_in), .go(go), .finish(finish),
      .range(a_range), .min_out(a_min), .max_out(a_max), .count(a_count),
      .valid(a_valid), .done(a_done), .busy(a_busy), .debug_error(a_err)
   );

   range_finder_stats #(.WIDTH(8), .CNT_WIDTH(16), .SIGNED(1)) dut_s (
      .clock(clock), .reset(reset), .data_in(data_in), .go(go), .finish(finish),
      .range(b_range), .min_out(b_min), .max_out(b_max), .count(b_count),
      .valid(b_valid), .done(b_done), .busy(b_busy), .debug_error(b_err)
   );

   // reference model: protocol flags plus the list of samples in the current run
   bit         m_run, m_err, e_valid, e_done;
   logic [7:0] samples[$];
   int         ea_rng, ea_min, ea_max, ea_cnt;
   int         eb_rng, eb_min, eb_max, eb_cnt;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0d expected=%0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic publish();
      int umin = 256, umax = -1, smin = 1000, smax = -1000;
      foreach (samples[i]) begin
         int u = int'(samples[i]);
         int s = (u >= 128) ? u - 256 : u;
         if (u < umin) umin = u;
         if (u > umax) umax = u;
         if (s < smin) smin = s;
         if (s > smax) smax = s;
      end
      ea_min = umin; ea_max = umax; ea_rng = umax - umin;
      ea_cnt = (samples.size() > 15) ? 15 : samples.size();
      eb_min = smin & 255; eb_max = smax & 255; eb_rng = (smax - smin) & 255;
      eb_cnt = (samples.size() > 65535) ? 65535 : samples.size();
   endtask

   task automatic model(input bit r, input bit g, input bit f, input logic [7:0] d);
      e_done = 1'b0;
      if (r) begin
         m_run = 0; m_err = 0; e_valid = 0;
         samples.delete();
         ea_rng = 0; ea_min = 0; ea_max = 0; ea_cnt = 0;
         eb_rng = 0; eb_min = 0; eb_max = 0; eb_cnt = 0;
      end else if (m_run) begin
         samples.push_back(d);
         if (f) begin
            m_run = 0; e_valid = 1; e_done = 1;
            publish();
         end
      end else if (g && !f) begin
         m_run = 1; m_err = 0; e_valid = 0;
         samples.delete();
         samples.push_back(d);
      end else if (!m_err && f) begin
         m_err = 1; e_valid = 0;
      end
   endtask

   task automatic check_all();
      chk("u_range", 32'(a_range), 32'(ea_rng));
      chk("u_min",   32'(a_min),   32'(ea_min));
      chk("u_max",   32'(a_max),   32'(ea_max));
      chk("u_count", 32'(a_count), 32'(ea_cnt));
      chk("u_valid", 32'(a_valid), 32'(e_valid));
      chk("u_done",  32'(a_done),  32'(e_done));
      chk("u_busy",  32'(a_busy),  32'(m_run));
      chk("u_err",   32'(a_err),   32'(m_err));
      chk("s_range", 32'(b_range), 32'(eb_rng));
      chk("s_min",   32'(b_min),   32'(eb_min));
      chk("s_max",   32'(b_max),   32'(eb_max));
      chk("s_count", 32'(b_count), 32'(eb_cnt));
      chk("s_valid", 32'(b_valid), 32'(e_valid));
      chk("s_done",  32'(b_done),  32'(e_done));
      chk("s_busy",  32'(b_busy),  32'(m_run));
      chk("s_err",   32'(b_err),   32'(m_err));
   endtask

   task automatic cycle(input bit r, input bit g, input bit f, input logic [7:0] d);
      reset = r; go = g; finish = f; data_in = d;
      @(posedge clock);
      model(r, g, f, d);
      #1;
      check_all();
   endtask

   initial begin
      // reset
      cycle(1, 0, 0, 8'h00);
      cycle(1, 1, 0, 8'h55);

      // basic unsigned run: expect min 5, max 200, range 195, count 4
      cycle(0, 1, 0, 8'd20);
      cycle(0, 0, 0, 8'd5);
      cycle(0, 0, 0, 8'd200);
      cycle(0, 0, 1, 8'd100);
      chk("plan_u_range", 32'(a_range), 32'd195);
      chk("plan_u_count", 32'(a_count), 32'd4);
      cycle(0, 0, 0, 8'd0);
      cycle(0, 0, 0, 8'd0);

      // finish in IDLE, then recover with a two-sample run
      cycle(0, 0, 1, 8'd1);
      cycle(0, 0, 0, 8'd0);
      cycle(0, 1, 0, 8'd7);
      cycle(0, 0, 1, 8'd9);
      chk("plan_recover_range", 32'(a_range), 32'd2);
      cycle(0, 0, 0, 8'd0);

      // go and finish together in IDLE, then again in ERROR
      cycle(0, 1, 1, 8'd3);
      cycle(0, 1, 1, 8'd4);
      chk("plan_err_sticky", 32'(a_err), 32'd1);
      cycle(0, 0, 1, 8'd4);
      cycle(0, 0, 0, 8'd0);

      // signed ordering: -3, 10, -128
      cycle(0, 1, 0, 8'hFD);
      cycle(0, 0, 0, 8'h0A);
      cycle(0, 0, 1, 8'h80);
      chk("plan_s_range", 32'(b_range), 32'd138);
      cycle(0, 0, 0, 8'd0);

      // 20-sample run saturates the 4-bit counter
      cycle(0, 1, 0, 8'($urandom));
      for (int i = 0; i < 18; i++) cycle(0, i[0], 0, 8'($urandom));
      cycle(0, 0, 1, 8'($urandom));
      chk("plan_sat_count", 32'(a_count), 32'd15);
      cycle(0, 0, 0, 8'd0);

      // reset after three samples, then a stray finish
      cycle(0, 1, 0, 8'd50);
      cycle(0, 0, 0, 8'd60);
      cycle(0, 0, 0, 8'd70);
      cycle(1, 0, 0, 8'd80);
      cycle(0, 0, 1, 8'd90);
      cycle(0, 0, 0, 8'd0);

      // random protocol traffic
      for (int i = 0; i < 600; i++) begin
         bit r, g, f;
         r = ($urandom_range(0, 99) < 2);
         g = ($urandom_range(0, 99) < 20);
         f = ($urandom_range(0, 99) < 12);
         cycle(r, g, f, 8'($urandom));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/range_finder_stats.md
Name: range_finder_stats

Overview:
Parametrised successor to the team's 8-bit range finder. It streams WIDTH-bit samples between a go strobe and a finish strobe, and tracks min, max, range (max-min) and sample count. It adds signed/unsigned compare, a registered result-valid/done pair and sticky protocol-error reporting. It sits behind the chip top (my_chip) on io_in/io_out.

Parameters:
WIDTH, 8, sample width in bits (>=2)
CNT_WIDTH, 16, sample-counter width in bits (>=2)
SIGNED, 0, 0 = unsigned compare, 1 = two's-complement compare

Ports:
clock  input  1  system clock, all state on rising edge
reset  input  1  synchronous, active-high; clears all state
data_in  input  WIDTH  sample, taken every cycle while a run is active
go  input  1  start strobe; data_in in this cycle is sample 1
finish  input  1  end strobe; data_in in this cycle is the last sample
range  output  WIDTH  max - min, unsigned
min_out  output  WIDTH  smallest sample (interpreted per SIGNED)
max_out  output  WIDTH  largest sample
count  output  CNT_WIDTH  samples taken, saturating
valid  output  1  results are valid; held until the next accepted go
done  output  1  one-cycle pulse when results become valid
busy  output  1  high while in RUN
debug_error  output  1  sticky protocol error

Behaviour:
- One clock, reset synchronous and active-high. Clock and reset are named clock and reset.
- Reset (any state, including mid-run): state = IDLE. range, min_out, max_out, count, valid, done, busy and debug_error all = 0.
- States: IDLE, RUN, ERROR.
- IDLE, go=1 and finish=0 -> RUN. Internal min=max=data_in, cnt=1. valid drops to 0 next cycle.
- IDLE, finish=1 (go=0 or go=1) -> ERROR. debug_error=1 next cycle. valid=0.
- IDLE, go=0 and finish=0: hold. All outputs keep their values.
- RUN, finish=0: include data_in in min/max. cnt = cnt+1, saturating at 2^CNT_WIDTH-1. go=1 here is ignored; the sample is still taken.
- RUN, finish=1: include data_in (go ignored). -> IDLE.
  - Next cycle: valid=1, done=1 for exactly one cycle.
  - range = max-min, plus min_out, max_out and the final count, all including the finish sample.
- Latency: finish at edge t -> results and valid at t+1.
- Minimum run is 2 samples (go and finish in distinct cycles).
- ERROR: debug_error stays 1. valid=0. finish is ignored.
  - go=1 and finish=0 starts a run exactly as from IDLE and clears debug_error the next cycle.
  - go=1 and finish=1 stays in ERROR.
- busy = 1 exactly while state == RUN.
- Compare: SIGNED=0 unsigned; SIGNED=1 two's complement.
- range is computed as the WIDTH+1-bit difference truncated to WIDTH. It is exact in both modes, since max-min <= 2^WIDTH-1.
- Outputs are registered. range, min_out, max_out and count change only when done fires or on reset. Intermediate values stay internal.
- count saturates; there is no wrap and no overflow flag.

Test Plan:
- WIDTH=8 unsigned. go with 20, then 5, 200, finish with 100 -> next cycle valid=1, done=1 for one cycle, min_out=5, max_out=200, range=195, count=4. valid stays 1 until the next go.
- finish=1 in IDLE -> debug_error=1 next cycle, valid=0. Then go with 7, finish with 9 -> debug_error=0 the cycle after go. Results: range=2, count=2.
- go=1 and finish=1 together in IDLE -> ERROR, debug_error=1. Repeat the same strobe in ERROR -> still 1.
- SIGNED=1, WIDTH=8. Samples 0xFD(-3), 0x0A(10), finish with 0x80(-128) -> min_out=0x80, max_out=0x0A, range=138, count=3.
- CNT_WIDTH=4. A 20-sample run -> count=15 (saturated). min and max are still correct.
- Reset asserted mid-run after 3 samples -> next cycle all outputs 0, busy=0. A following finish=1 -> debug_error=1.
